// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream program loader.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package program_loader_pkg;

    // Frame start marker used when the instantiating design does not override it.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // A LEN byte of zero stands for a full 256-word image.
    localparam logic [8:0] LEN_FULL = 9'd256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // Decode the LEN byte into a 9-bit word count.
    function automatic logic [8:0] word_count(input logic [7:0] len);
        return (len == 8'd0) ? LEN_FULL : {1'b0, len};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-receive and program-memory write bundle of the program loader.
// Latency: n/a (signal grouping only).
// Backpressure: rx_ready qualifies rx_valid; the write side has no backpressure.
// Modports: master = the loader (drives rx_ready, the write port and status),
//           slave  = its surroundings (byte source, program memory, CPU control).
interface program_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Loads a framed SYNC,LEN,(HI,LO)*n[,CHK] byte image into the 256x16 program store.
// Latency: wr_en/wr_addr/wr_data valid the cycle after the LO byte is accepted.
// Backpressure: none; rx_ready is high from the first edge after reset onwards.
// Ports: clock, reset (async, active-high); bus (program_loader_if.master):
//   rx_data/rx_valid/rx_ready byte input, wr_en/wr_addr/wr_data memory write,
//   cpu_hold/done/error status.
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds the trailing CHK byte and the ERR path.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.master bus
);

    state_t      state;
    logic [8:0]  word_cnt;
    logic [8:0]  word_idx;
    logic [7:0]  opcode;
    logic        rx_ready_q;
    logic        wr_en_q;
    logic [7:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic        hold_q;
    logic        done_q;
    logic        accept;
    logic        last_word;

    assign accept    = bus.rx_valid & rx_ready_q;
    // Index is 9 bits so a full 256-word image ends when it would reach 256.
    assign last_word = (word_idx + 9'd1) == word_cnt;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] chk_total;
    logic       error_q;

    assign chk_total = sum + bus.rx_data;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_cnt   <= 9'd0;
            word_idx   <= 9'd0;
            opcode     <= 8'd0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 16'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum        <= 8'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            rx_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        word_cnt <= word_count(bus.rx_data);
                        word_idx <= 9'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum      <= bus.rx_data;
`endif
                        state    <= ST_HI;
                    end
                    ST_HI: begin
                        opcode <= bus.rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum    <= sum + bus.rx_data;
`endif
                        state  <= ST_LO;
                    end
                    ST_LO: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= word_idx[7:0];
                        wr_data_q <= {opcode, bus.rx_data};
                        word_idx  <= word_idx + 9'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum       <= sum + bus.rx_data;
                        state     <= last_word ? ST_CHK : ST_HI;
`else
                        if (last_word) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            hold_q <= 1'b0;
                        end else begin
                            state  <= ST_HI;
                        end
`endif
                    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (chk_total == 8'd0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            hold_q <= 1'b0;
                        end else begin
                            state   <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
`endif
                    // A new frame re-arms the hold before any word is overwritten.
                    ST_DONE, ST_ERR: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            state  <= ST_LEN;
                            hold_q <= 1'b1;
                            done_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            error_q <= 1'b0;
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cpu_hold = hold_q;
    assign bus.done     = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign bus.error    = error_q;
`else
    assign bus.error    = 1'b0;
`endif

endmodule
